// File: rtl/definitions_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter.
// Provides the opcode enumeration, the instruction word, the arbiter
// output-slot state type and the number of requesters.
package definitions_pkg;

  localparam int NUM_REQ = 2;

  // Three-bit opcode field; the encodings not listed are undefined and
  // produce a zero result.
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } instruction_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU (AND, OR, ADD, SUB; modulo 2^32).
// Ports: iw    - instruction (opcode, a, b)
//        result/zero - computed value and its zero flag
module alu
  import definitions_pkg::*;
(
  input  instruction_t iw,
  output logic [31:0]  result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (iw.opcode)
      OP_AND:  result = iw.a & iw.b;
      OP_OR:   result = iw.a | iw.b;
      OP_ADD:  result = iw.a + iw.b;
      OP_SUB:  result = iw.a - iw.b;
      default: result = '0;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin
// arbitration and a single registered response slot (one-cycle latency).
// Ports: req_valid/req_iw/req_ready - per-requester request channel
//        rsp_valid/rsp_ready/rsp_result/rsp_zero/rsp_id - response channel
//        op_count - count of completed response transfers (wraps)
module alu_arbiter
  import definitions_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic         [NUM_REQ-1:0]    req_valid,
  input  instruction_t [NUM_REQ-1:0]    req_iw,
  output logic         [NUM_REQ-1:0]    req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic         [31:0]           rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_id,
  output logic         [CNT_W-1:0]      op_count
);

  arb_state_t           state_q, state_d;
  logic                 last_q;
  logic [NUM_REQ-1:0]   grant;
  logic                 slot_open;
  logic                 accept;
  logic                 xfer;
  logic                 win_id;
  instruction_t         sel_iw;
  logic [31:0]          alu_result;
  logic                 alu_zero;

  // Round-robin grant: a lone requester wins; on contention the requester
  // that did not win the most recent accept gets the slot.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // The slot can take a new result if it is empty or is being drained this
  // cycle. Gating with rst_n keeps req_ready low throughout reset.
  assign slot_open = rst_n && ((state_q == EMPTY) || rsp_ready);
  assign req_ready = slot_open ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign win_id    = grant[1];
  assign sel_iw    = req_iw[win_id];
  assign rsp_valid = (state_q == FULL);
  assign xfer      = rsp_valid && rsp_ready;

  alu u_alu (
    .iw     (sel_iw),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (xfer && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Response payload and fairness pointer only move on an accept, so the
  // payload is held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
      last_q     <= 1'b1;
    end else if (accept) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= win_id;
      last_q     <= win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (xfer) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import definitions_pkg::*;

  localparam int CNT_W = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic         [1:0]         req_valid;
  instruction_t [1:0]         req_iw;
  logic         [1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic         [31:0]        rsp_result;
  logic                       rsp_zero;
  logic                       rsp_id;
  logic         [CNT_W-1:0]   op_count;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_iw     (req_iw),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .op_count   (op_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the response slot as a record plus a fairness pointer.
  logic        m_valid;
  logic [31:0] m_result;
  logic        m_zero;
  logic        m_id;
  int          m_count;
  logic        m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t op, input logic [31:0] a, input logic [31:0] b);
    instruction_t i;
    i.opcode = op;
    i.a      = a;
    i.b      = b;
    return i;
  endfunction

  function automatic logic [31:0] ref_alu(input instruction_t i);
    case (i.opcode)
      OP_AND:  return i.a & i.b;
      OP_OR:   return i.a | i.b;
      OP_ADD:  return i.a + i.b;
      OP_SUB:  return i.a - i.b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_ready(input logic [1:0] v, input logic rr);
    if (!rst_n) return 2'b00;
    if (m_valid && !rr) return 2'b00;
    if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_result = '0;
    m_zero   = 1'b0;
    m_id     = 1'b0;
    m_count  = 0;
    m_last   = 1'b1;
  endtask

  task automatic check_outputs();
    chk("rsp_valid",  {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_result", rsp_result, m_result);
    chk("rsp_zero",   {31'd0, rsp_zero}, {31'd0, m_zero});
    chk("rsp_id",     {31'd0, rsp_id}, {31'd0, m_id});
    chk("op_count",   {30'd0, op_count}, m_count);
  endtask

  // One clock cycle: drive at the falling edge, check ready mid-phase,
  // advance the model at the rising edge, check outputs at the next fall.
  task automatic cycle(input logic [1:0] v, input instruction_t i0,
                       input instruction_t i1, input logic rr);
    logic [1:0] er;
    logic       xfer;
    logic       w;
    req_valid = v;
    req_iw[0] = i0;
    req_iw[1] = i1;
    rsp_ready = rr;
    #1;
    er = exp_ready(v, rr);
    chk("req_ready", {30'd0, req_ready}, {30'd0, er});
    @(posedge clk);
    xfer = m_valid && rr;
    if (er != 2'b00) begin
      w        = er[1];
      m_result = ref_alu(w ? i1 : i0);
      m_zero   = (m_result == 32'd0);
      m_id     = w;
      m_last   = w;
      m_valid  = 1'b1;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (xfer) m_count = (m_count + 1) % (1 << CNT_W);
    @(negedge clk);
    check_outputs();
  endtask

  instruction_t nop;
  logic         prev_id;

  initial begin
    nop       = mk(OP_AND, 32'd0, 32'd0);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_iw[0] = nop;
    req_iw[1] = nop;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    check_outputs();
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Single operation
    cycle(2'b01, mk(OP_ADD, 32'd5, 32'd7), nop, 1'b1);
    chk("single_result", rsp_result, 32'd12);
    chk("single_id", {31'd0, rsp_id}, 32'd0);
    cycle(2'b00, nop, nop, 1'b1);
    chk("single_count", {30'd0, op_count}, 32'd1);

    // Contention: grants alternate every cycle
    prev_id = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(2'b11, mk(OP_SUB, 32'd9, 32'd9), mk(OP_OR, 32'hF0, 32'h0F), 1'b1);
      chk("alternate_id", {31'd0, rsp_id}, {31'd0, ~prev_id});
      chk("alternate_result", rsp_result, rsp_id ? 32'hFF : 32'h0);
      prev_id = rsp_id;
    end
    cycle(2'b00, nop, nop, 1'b1);

    // Back-pressure
    cycle(2'b01, mk(OP_ADD, 32'h1200, 32'h34), nop, 1'b0);
    chk("bp_result", rsp_result, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      cycle(2'b10, nop, mk(OP_AND, 32'hFF00, 32'h0FF0), 1'b0);
      chk("bp_hold_ready", {30'd0, req_ready}, 32'd0);
      chk("bp_hold_result", rsp_result, 32'h1234);
    end
    cycle(2'b10, nop, mk(OP_AND, 32'hFF00, 32'h0FF0), 1'b1);
    chk("bp_release_id", {31'd0, rsp_id}, 32'd1);
    chk("bp_release_result", rsp_result, 32'h0F00);

    // Reset while FULL
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("midreset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_count", {30'd0, op_count}, 32'd0);
    chk("midreset_ready", {30'd0, req_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // First contention after reset goes to requester 0; ADD wraps to zero
    cycle(2'b11, mk(OP_ADD, 32'hFFFF_FFFF, 32'd1), mk(OP_SUB, 32'd3, 32'd1), 1'b1);
    chk("postreset_id", {31'd0, rsp_id}, 32'd0);
    chk("wrap_result", rsp_result, 32'd0);
    chk("wrap_zero", {31'd0, rsp_zero}, 32'd1);
    for (int k = 0; k < 4; k++)
      cycle(2'b01, mk(OP_OR, k, 32'd1), nop, 1'b1);
    cycle(2'b00, nop, nop, 1'b1);
    chk("count_wrap", {30'd0, op_count}, 32'd1);

    // Undefined opcode from requester 1
    cycle(2'b10, nop, mk(opcode_t'(3'd6), 32'hDEAD, 32'hBEEF), 1'b1);
    chk("undef_result", rsp_result, 32'd0);
    chk("undef_zero", {31'd0, rsp_zero}, 32'd1);
    chk("undef_id", {31'd0, rsp_id}, 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      instruction_t r0, r1;
      logic [31:0]  a0, a1;
      a0 = $urandom;
      a1 = $urandom;
      r0 = mk(opcode_t'(3'($urandom_range(0, 7))), a0, ($urandom_range(0, 3) == 0) ? a0 : $urandom);
      r1 = mk(opcode_t'(3'($urandom_range(0, 7))), a1, ($urandom_range(0, 3) == 0) ? a1 : $urandom);
      cycle(2'($urandom_range(0, 3)), r0, r1, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_iw  input  2 x instruction_t  per-requester instruction (opcode, a, b).
REQ-006 req_ready  output  2  per-requester accept; a request transfers when req_valid[i] && req_ready[i].
REQ-007 rsp_valid  output  1  response valid.
REQ-008 rsp_ready  input  1  consumer accept; a response transfers when rsp_valid && rsp_ready.
REQ-009 rsp_result  output  32  ALU result of the accepted instruction.
REQ-010 rsp_zero  output  1  ALU zero flag of the accepted instruction.
REQ-011 rsp_id  output  1  index of the requester that issued the response.
REQ-012 op_count  output  CNT_W  number of completed response transfers.

Function
REQ-013 The block SHALL share one alu instance between two requesters; at most one request SHALL be accepted per cycle.
REQ-014 Output state machine SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 EMPTY -> FULL on an accept; FULL -> EMPTY on a response transfer without an accept; FULL stays FULL on a simultaneous response transfer and accept (back-to-back); otherwise the state is held.
REQ-016 The slot SHALL be open when the state is EMPTY or rsp_ready=1; req_ready SHALL be 0 on both bits when the slot is closed.
REQ-017 Grant SHALL be combinational: one valid requester wins alone; when both are valid, the requester not served by the most recent accept wins; req_ready[i] = slot open && grant[i].
REQ-018 The last-served pointer SHALL update only on an accept; with idle or single-requester cycles, fairness SHALL still alternate on the next contention.
REQ-019 The granted req_iw SHALL drive the alu combinationally; on accept, its result and zero flag SHALL be registered into rsp_result and rsp_zero, and the winner index into rsp_id.
REQ-020 Latency SHALL be one cycle: accept at edge N -> rsp_valid=1 after edge N; sustained throughput SHALL be one op per cycle while rsp_ready=1.
REQ-021 While rsp_valid=1 and rsp_ready=0, rsp_result, rsp_zero and rsp_id SHALL remain stable.
REQ-022 Arithmetic SHALL be 32-bit modulo 2^32 (ADD/SUB wrap, no overflow flag); opcodes other than AND/OR/ADD/SUB SHALL give result 0, zero 1.
REQ-023 op_count SHALL increment by 1 per response transfer and wrap from 2^CNT_W-1 to 0.
REQ-024 Dropping req_valid without a transfer SHALL have no effect; req_iw SHALL be sampled only on accept.

Reset
REQ-025 While rst_n=0: state EMPTY, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_id 0, op_count 0, last-served pointer = 1 so requester 0 wins first contention.
REQ-026 Reset asserted mid-operation SHALL discard any held response immediately (no transfer, no count); req_ready SHALL be 0 while rst_n=0.

Structure
REQ-027 instruction_t and the opcode enumeration SHALL come from definitions_pkg; arb_state_t (EMPTY, FULL) and NUM_REQ=2 SHALL be added there.
REQ-028 The block SHALL instantiate the existing alu as its only sub-module; arbitration, slot register and counter SHALL be local.

Verification
REQ-029 Single op: req0 ADD a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, result 12, zero 0, id 0, op_count 1.
REQ-030 Contention: both valid every cycle, req0 SUB 9-9, req1 OR 0xF0|0x0F -> responses alternate id 0 (result 0, zero 1) then id 1 (result 0xFF), 1 per cycle.
REQ-031 Back-pressure: FULL with result 0x1234, rsp_ready=0 for 3 cycles -> req_ready=00, outputs stable; rsp_ready=1 -> transfer and same-cycle accept of pending request.
REQ-032 Wrap: ADD 0xFFFFFFFF+1 -> result 0, zero 1; CNT_W=2 with 5 transfers -> op_count 1.
REQ-033 Reset mid-operation: rst_n low while FULL -> rsp_valid 0, op_count 0 immediately; after release, contention grants requester 0 first.
REQ-034 Undefined opcode from req1 -> result 0, zero 1, id 1.
